ysyx_25040101_lsu: RTL and testbench

Multi-cycle load/store unit between the decode/execute stage and the data-memory bus. It consumes the one-hot memory-access enables and ALU-computed address produced by decode and drives a valid/ready request/response memory bus. It aligns store data into byte lanes with a write mask and returns byte-extracted, zero- or sign-extended load data. It stalls the core via `busy_o` until the bus transaction completes.

---
 rtl/ysyx_25040101_lsu.sv | 187 ++++++++++++++++++
 tb/tb_ysyx_25040101_lsu.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040101_lsu.sv
// ysyx_25040101_lsu -- multi-cycle load/store unit.
//
// Sits between decode/execute and a valid/ready data-memory bus. It accepts
// one memory op at a time and issues a single word-aligned bus request.
// Store data is replicated into byte lanes with a write mask. Load data is
// extracted from the returned word and zero- or sign-extended.
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   req_valid_i           core presents an op (held until done_o)
//   rd_*_i / wr_*_i       one-hot access enables (lbu/lb/lhu/lh/lw/sb/sh/sw)
//   addr_i, wdata_i       effective byte address, unaligned store data
//   busy_o, done_o        op in flight / one-cycle completion pulse
//   rdata_o, err_o        load result and error status, valid with done_o
//   mem_req_*             bus request channel (word address, lane data, mask)
//   mem_rsp_*             bus response channel (raw word, error)
//
// Build option: define LSU_MISALIGN_CHK_EN to reject misaligned halfword and
// word accesses with err_o instead of issuing them to the bus.

module ysyx_25040101_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  input  logic              rd_1b_i,
  input  logic              rd_1b_sext_i,
  input  logic              rd_2b_i,
  input  logic              rd_2b_sext_i,
  input  logic              rd_4b_i,
  input  logic              wr_1b_i,
  input  logic              wr_2b_i,
  input  logic              wr_4b_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_req_wen_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [DATA_W-1:0] mem_req_wdata_o,
  output logic [3:0]        mem_req_wmask_o,
  input  logic              mem_rsp_valid_i,
  output logic              mem_rsp_ready_o,
  input  logic [DATA_W-1:0] mem_rsp_rdata_i,
  input  logic              mem_rsp_err_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2, DONE = 2'd3} state_t;

  state_t state_reg, state_next;

  // Enable vector, bit order: lbu, lb, lhu, lh, lw, sb, sh, sw.
  logic [7:0] op_en;
  logic [1:0] off;
  logic       any_en, multi_en, misalign, bad_op, accept;

  assign op_en    = {wr_4b_i, wr_2b_i, wr_1b_i, rd_4b_i,
                     rd_2b_sext_i, rd_2b_i, rd_1b_sext_i, rd_1b_i};
  assign off      = addr_i[1:0];
  assign any_en   = |op_en;
  // Clearing the lowest set bit leaves something only if two or more are set.
  assign multi_en = (op_en & (op_en - 8'd1)) != 8'd0;

`ifdef LSU_MISALIGN_CHK_EN
  assign misalign = ((rd_2b_i | rd_2b_sext_i | wr_2b_i) & off[0]) |
                    ((rd_4b_i | wr_4b_i) & (off != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign bad_op = multi_en | misalign;
  assign accept = (state_reg == IDLE) & req_valid_i & any_en;

  // Store lane formatting from the live inputs; latched at accept.
  logic [DATA_W-1:0] st_data;
  logic [3:0]        st_mask;
  logic              st_wen;

  always_comb begin
    st_data = '0;
    st_mask = 4'b0000;
    st_wen  = wr_1b_i | wr_2b_i | wr_4b_i;
    if (wr_1b_i) begin
      st_data = {4{wdata_i[7:0]}};
      st_mask = 4'b0001 << off;
    end else if (wr_2b_i) begin
      st_data = {2{wdata_i[15:0]}};
      st_mask = 4'b0011 << {off[1], 1'b0};
    end else if (wr_4b_i) begin
      st_data = wdata_i;
      st_mask = 4'b1111;
    end
  end

  logic [7:0]        op_reg;
  logic [1:0]        off_reg;
  logic [ADDR_W-1:0] req_addr_reg;
  logic [DATA_W-1:0] req_wdata_reg;
  logic [3:0]        req_wmask_reg;
  logic              req_wen_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;

  // Load extraction from the raw response word; only sampled into rdata_reg,
  // so nothing on the response bus reaches the outputs combinationally.
  logic [DATA_W-1:0] byte_shift, half_shift, load_data;

  assign byte_shift = mem_rsp_rdata_i >> {off_reg, 3'b000};
  assign half_shift = mem_rsp_rdata_i >> {off_reg[1], 4'b0000};

  always_comb begin
    load_data = '0;
    if (op_reg[0])      load_data = {24'd0, byte_shift[7:0]};
    else if (op_reg[1]) load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
    else if (op_reg[2]) load_data = {16'd0, half_shift[15:0]};
    else if (op_reg[3]) load_data = {{16{half_shift[15]}}, half_shift[15:0]};
    else if (op_reg[4]) load_data = mem_rsp_rdata_i;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = bad_op ? DONE : REQ;
      REQ:     if (mem_req_ready_i) state_next = RSP;
      RSP:     if (mem_rsp_valid_i) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy_o          = (state_reg != IDLE);
    done_o          = (state_reg == DONE);
    mem_req_valid_o = (state_reg == REQ);
    mem_rsp_ready_o = (state_reg == RSP);
  end

  // Op/payload capture and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg        <= '0;
      off_reg       <= '0;
      req_addr_reg  <= '0;
      req_wdata_reg <= '0;
      req_wmask_reg <= '0;
      req_wen_reg   <= 1'b0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
    end else if (accept) begin
      rdata_reg <= '0;
      err_reg   <= bad_op;
      if (!bad_op) begin
        op_reg        <= op_en;
        off_reg       <= off;
        req_addr_reg  <= {addr_i[ADDR_W-1:2], 2'b00};
        req_wdata_reg <= st_data;
        req_wmask_reg <= st_mask;
        req_wen_reg   <= st_wen;
      end
    end else if ((state_reg == RSP) && mem_rsp_valid_i) begin
      err_reg   <= mem_rsp_err_i;
      rdata_reg <= mem_rsp_err_i ? '0 : load_data;
    end
  end

  assign mem_req_addr_o  = req_addr_reg;
  assign mem_req_wdata_o = req_wdata_reg;
  assign mem_req_wmask_o = req_wmask_reg;
  assign mem_req_wen_o   = req_wen_reg;
  assign rdata_o         = rdata_reg;
  assign err_o           = err_reg;

endmodule

// File: tb/tb_ysyx_25040101_lsu.sv
// Testbench for ysyx_25040101_lsu: drives single ops, plays the memory bus
// with configurable request/response stalls, and checks each completion
// against expectations queued when the op was driven.

module tb_ysyx_25040101_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic [7:0]  en = 8'd0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        busy_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic        mem_req_valid_o, mem_req_wen_o, mem_rsp_ready_o;
  logic        mem_req_ready_i = 1'b0;
  logic [31:0] mem_req_addr_o, mem_req_wdata_o;
  logic [3:0]  mem_req_wmask_o;
  logic        mem_rsp_valid_i = 1'b0;
  logic [31:0] mem_rsp_rdata_i = '0;
  logic        mem_rsp_err_i = 1'b0;

  // Enable bit positions in en.
  localparam logic [7:0] LBU = 8'h01, LB = 8'h02, LHU = 8'h04, LH = 8'h08,
                         LW  = 8'h10, SB = 8'h20, SH  = 8'h40, SW = 8'h80;

  always #5 clk = ~clk;

  ysyx_25040101_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid_i     (req_valid_i),
    .rd_1b_i         (en[0]),
    .rd_1b_sext_i    (en[1]),
    .rd_2b_i         (en[2]),
    .rd_2b_sext_i    (en[3]),
    .rd_4b_i         (en[4]),
    .wr_1b_i         (en[5]),
    .wr_2b_i         (en[6]),
    .wr_4b_i         (en[7]),
    .addr_i          (addr_i),
    .wdata_i         (wdata_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .rdata_o         (rdata_o),
    .err_o           (err_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_wen_o   (mem_req_wen_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_wdata_o (mem_req_wdata_o),
    .mem_req_wmask_o (mem_req_wmask_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_ready_o (mem_rsp_ready_o),
    .mem_rsp_rdata_i (mem_rsp_rdata_i),
    .mem_rsp_err_i   (mem_rsp_err_i)
  );

  typedef struct {
    string       name;
    logic        bus;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;
    logic        err;
    int          done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one op at cycle 0, act as the bus, compare at done_o.
  task automatic do_op(input string name, input logic [7:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input int req_stall, input int rsp_stall,
                       input logic [31:0] rsp_data, input logic rsp_err,
                       input logic e_bus, input logic e_wen, input logic [31:0] e_addr,
                       input logic [31:0] e_wdata, input logic [3:0] e_mask,
                       input logic [31:0] e_rdata, input logic e_err, input int e_done);
    exp_t e;
    int   cyc, req_wait, rsp_wait;
    logic saw_req, got_done;
    e.name = name; e.bus = e_bus; e.wen = e_wen; e.addr = e_addr; e.wdata = e_wdata;
    e.mask = e_mask; e.rdata = e_rdata; e.err = e_err; e.done_cyc = e_done;
    exp_q.push_back(e);
    req_valid_i = 1'b1; en = op; addr_i = addr; wdata_i = wdata;
    cyc = 0; req_wait = 0; rsp_wait = 0; saw_req = 1'b0; got_done = 1'b0;
    while (!got_done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
      mem_rsp_err_i = 1'b0;   mem_rsp_rdata_i = '0;
      if (done_o) begin
        got_done = 1'b1;
        req_valid_i = 1'b0; en = 8'd0;
        e = exp_q.pop_front();
        check_val({e.name, "_done_cyc"}, cyc, e.done_cyc);
        check_val({e.name, "_bus"}, {31'd0, saw_req}, {31'd0, e.bus});
        check_val({e.name, "_rdata"}, rdata_o, e.rdata);
        check_val({e.name, "_err"}, {31'd0, err_o}, {31'd0, e.err});
        $display("txn %s done at cycle %0d rdata %h err %b", e.name, cyc, rdata_o, err_o);
      end else begin
        check_val({name, "_busy"}, {31'd0, busy_o}, 32'd1);
        if (mem_req_valid_o) begin
          saw_req = 1'b1;
          check_val({name, "_req_addr"}, mem_req_addr_o, e_addr);
          check_val({name, "_req_wen"}, {31'd0, mem_req_wen_o}, {31'd0, e_wen});
          check_val({name, "_req_mask"}, {28'd0, mem_req_wmask_o}, {28'd0, e_mask});
          if (e_wen) check_val({name, "_req_wdata"}, mem_req_wdata_o, e_wdata);
          if (req_wait >= req_stall) mem_req_ready_i = 1'b1;
          else req_wait++;
        end
        if (mem_rsp_ready_o) begin
          if (rsp_wait >= rsp_stall) begin
            mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = rsp_data; mem_rsp_err_i = rsp_err;
          end else begin
            rsp_wait++;
          end
        end
      end
    end
    if (!got_done) begin
      check_val({name, "_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
      req_valid_i = 1'b0; en = 8'd0;
    end
    @(posedge clk); #1;
    check_val({name, "_done_pulse"}, {31'd0, done_o}, 32'd0);
    check_val({name, "_idle"}, {31'd0, busy_o}, 32'd0);
    check_val({name, "_rdata_held"}, rdata_o, e_rdata);
  endtask

  initial begin
    int k;
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", {31'd0, busy_o}, 32'd0);
    check_val("rst_done", {31'd0, done_o}, 32'd0);
    check_val("rst_rdata", rdata_o, 32'd0);
    check_val("rst_err", {31'd0, err_o}, 32'd0);
    check_val("rst_req_valid", {31'd0, mem_req_valid_o}, 32'd0);
    check_val("rst_req_addr", mem_req_addr_o, 32'd0);
    check_val("rst_req_wdata", mem_req_wdata_o, 32'd0);
    check_val("rst_req_mask", {28'd0, mem_req_wmask_o}, 32'd0);
    check_val("rst_rsp_ready", {31'd0, mem_rsp_ready_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //     name   op   addr          wdata        rqs rss rsp_data     rerr bus wen e_addr        e_wdata      mask     e_rdata      err done
    do_op("sw",   SW,  32'h80000004, 32'hDEADBEEF, 0, 0, 32'h0,        0,  1,  1,  32'h80000004, 32'hDEADBEEF, 4'b1111, 32'h0,        0,  3);
    do_op("sb",   SB,  32'h80000003, 32'h000000A5, 0, 0, 32'h0,        0,  1,  1,  32'h80000000, 32'hA5A5A5A5, 4'b1000, 32'h0,        0,  3);
    do_op("sb1",  SB,  32'h80000011, 32'hFFFFFF5A, 0, 0, 32'h0,        0,  1,  1,  32'h80000010, 32'h5A5A5A5A, 4'b0010, 32'h0,        0,  3);
    do_op("sh",   SH,  32'h10000006, 32'h1234BEEF, 0, 0, 32'h0,        0,  1,  1,  32'h10000004, 32'hBEEFBEEF, 4'b1100, 32'h0,        0,  3);
    do_op("lb",   LB,  32'h80000002, 32'h0,        0, 0, 32'h12F45678, 0,  1,  0,  32'h80000000, 32'h0,        4'b0000, 32'hFFFFFFF4, 0,  3);
    do_op("lbu",  LBU, 32'h80000002, 32'h0,        0, 0, 32'h12F45678, 0,  1,  0,  32'h80000000, 32'h0,        4'b0000, 32'h000000F4, 0,  3);
    do_op("lb1",  LB,  32'h80000021, 32'h0,        0, 0, 32'h00007F00, 0,  1,  0,  32'h80000020, 32'h0,        4'b0000, 32'h0000007F, 0,  3);
    do_op("lh",   LH,  32'h80000002, 32'h0,        0, 0, 32'h80010000, 0,  1,  0,  32'h80000000, 32'h0,        4'b0000, 32'hFFFF8001, 0,  3);
    do_op("lhu",  LHU, 32'h40000000, 32'h0,        0, 0, 32'h1234F00D, 0,  1,  0,  32'h40000000, 32'h0,        4'b0000, 32'h0000F00D, 0,  3);
    do_op("bp",   LW,  32'h80000008, 32'h0,        5, 3, 32'hCAFEF00D, 0,  1,  0,  32'h80000008, 32'h0,        4'b0000, 32'hCAFEF00D, 0, 11);
`ifdef LSU_MISALIGN_CHK_EN
    do_op("lh_mis", LH, 32'h80000001, 32'h0,       0, 0, 32'h1234ABCD, 0,  0,  0,  32'h80000000, 32'h0,        4'b0000, 32'h0,        1,  1);
`else
    do_op("lh_mis", LH, 32'h80000001, 32'h0,       0, 0, 32'h1234ABCD, 0,  1,  0,  32'h80000000, 32'h0,        4'b0000, 32'hFFFFABCD, 0,  3);
`endif
    do_op("multi", LW | SW, 32'h80000000, 32'h0,   0, 0, 32'h0,        0,  0,  0,  32'h80000000, 32'h0,        4'b0000, 32'h0,        1,  1);
    do_op("rsperr", LW, 32'h80000000, 32'h0,       0, 1, 32'h55555555, 1,  1,  0,  32'h80000000, 32'h0,        4'b0000, 32'h0,        1,  4);
    do_op("err_clr", LBU, 32'h80000003, 32'h0,     1, 0, 32'hAB000000, 0,  1,  0,  32'h80000000, 32'h0,        4'b0000, 32'h000000AB, 0,  4);

    // Zero enables with req_valid: ignored.
    req_valid_i = 1'b1; en = 8'd0; addr_i = 32'h80000000;
    repeat (3) begin
      @(posedge clk); #1;
      check_val("noen_busy", {31'd0, busy_o}, 32'd0);
      check_val("noen_req_valid", {31'd0, mem_req_valid_o}, 32'd0);
    end
    req_valid_i = 1'b0;
    $display("txn noen ignored busy %b", busy_o);

    // Reset while waiting for a response.
    req_valid_i = 1'b1; en = LW; addr_i = 32'h80000040;
    k = 0;
    while (!mem_rsp_ready_o && k < 10) begin
      @(posedge clk); #1;
      k++;
      if (mem_req_valid_o) begin
        mem_req_ready_i = 1'b1;
        req_valid_i = 1'b0; en = 8'd0;
      end else begin
        mem_req_ready_i = 1'b0;
      end
    end
    mem_req_ready_i = 1'b0;
    check_val("rst_rsp_reached", {31'd0, mem_rsp_ready_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_busy", {31'd0, busy_o}, 32'd0);
    check_val("arst_done", {31'd0, done_o}, 32'd0);
    check_val("arst_rdata", rdata_o, 32'd0);
    check_val("arst_err", {31'd0, err_o}, 32'd0);
    check_val("arst_req_valid", {31'd0, mem_req_valid_o}, 32'd0);
    check_val("arst_req_addr", mem_req_addr_o, 32'd0);
    check_val("arst_rsp_ready", {31'd0, mem_rsp_ready_o}, 32'd0);
    $display("txn arst outputs cleared busy %b rsp_ready %b", busy_o, mem_rsp_ready_o);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("sw_post", SW, 32'h80000100, 32'h01234567, 0, 0, 32'h0, 0, 1, 1, 32'h80000100, 32'h01234567, 4'b1111, 32'h0, 0, 3);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
